// File: rtl/midi_pkg.sv
// Shared types and widths for the MIDI voice allocator.
// Voice record, FSM state encoding and MIDI field widths.
package midi_pkg;

   localparam int unsigned CH_W      = 4;
   localparam int unsigned DATA_W    = 7;
   // Ages are stored at this width; the allocator saturates at its own AGE_W (<= AGE_MAX_W).
   localparam int unsigned AGE_MAX_W = 16;

   typedef enum logic [0:0] {
      StIdle,
      StAlloc
   } state_e;

   typedef struct packed {
      logic                 gate;
      logic [CH_W-1:0]      ch;
      logic [DATA_W-1:0]    note;
      logic [DATA_W-1:0]    vel;
      logic [AGE_MAX_W-1:0] age;
   } voice_t;

endpackage

// File: rtl/midi_voice_select.sv
// Combinational voice search: gated ch+note match, lowest free slot, and oldest slot.
module midi_voice_select
   import midi_pkg::*;
#(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned IDX_W      = $clog2(NUM_VOICES)
) (
   input  voice_t [NUM_VOICES-1:0] voices,
   input  logic [CH_W-1:0]         ch,
   input  logic [DATA_W-1:0]       note,
   output logic                    match_found,
   output logic [IDX_W-1:0]        match_idx,
   output logic                    free_found,
   output logic [IDX_W-1:0]        free_idx,
   output logic [IDX_W-1:0]        oldest_idx
);

   logic [AGE_MAX_W-1:0] oldest_age;

   // Descending scans so the lowest matching index is the one left standing.
   always_comb begin
      match_found = 1'b0;
      match_idx   = '0;
      free_found  = 1'b0;
      free_idx    = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (voices[i].gate && voices[i].ch == ch && voices[i].note == note) begin
            match_found = 1'b1;
            match_idx   = IDX_W'(i);
         end
         if (!voices[i].gate) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   // Strict greater-than keeps the lowest index on an age tie.
   always_comb begin
      oldest_idx = '0;
      oldest_age = voices[0].age;
      for (int i = 1; i < NUM_VOICES; i++) begin
         if (voices[i].age > oldest_age) begin
            oldest_age = voices[i].age;
            oldest_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: takes one decoded MIDI note event every two cycles and
// assigns it to a voice slot by match, first-free, or oldest-steal.
module midi_voice_allocator
   import midi_pkg::*;
#(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned AGE_W      = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               ev_valid,
   output logic                               ev_ready,
   input  logic                               ev_on,
   input  logic                               ev_off,
   input  logic [CH_W-1:0]                    ev_ch,
   input  logic [DATA_W-1:0]                  ev_note,
   input  logic [DATA_W-1:0]                  ev_vel,
   output logic [NUM_VOICES-1:0]              gate,
   output logic [NUM_VOICES-1:0]              trig,
   output logic [NUM_VOICES-1:0][CH_W-1:0]    voice_ch,
   output logic [NUM_VOICES-1:0][DATA_W-1:0]  voice_note,
   output logic [NUM_VOICES-1:0][DATA_W-1:0]  voice_vel,
   output logic                               steal,
   output logic                               err
);

   localparam int unsigned IDX_W = $clog2(NUM_VOICES);
   localparam logic [AGE_MAX_W-1:0] AgeSat = AGE_MAX_W'((32'd1 << AGE_W) - 32'd1);

   state_e                  state_q, state_d;
   logic                    on_q, on_d;
   logic                    off_q, off_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic [DATA_W-1:0]       note_q, note_d;
   logic [DATA_W-1:0]       vel_q, vel_d;
   voice_t [NUM_VOICES-1:0] voice_q, voice_d;
   logic [NUM_VOICES-1:0]   trig_q, trig_d;
   logic                    steal_q, steal_d;
   logic                    err_q, err_d;

   logic                    match_found, free_found;
   logic [IDX_W-1:0]        match_idx, free_idx, oldest_idx;
   logic [IDX_W-1:0]        target_idx;

   midi_voice_select #(
      .NUM_VOICES (NUM_VOICES),
      .IDX_W      (IDX_W)
   ) u_select (
      .voices      (voice_q),
      .ch          (ch_q),
      .note        (note_q),
      .match_found (match_found),
      .match_idx   (match_idx),
      .free_found  (free_found),
      .free_idx    (free_idx),
      .oldest_idx  (oldest_idx)
   );

   always_comb begin
      state_d    = state_q;
      on_d       = on_q;
      off_d      = off_q;
      ch_d       = ch_q;
      note_d     = note_q;
      vel_d      = vel_q;
      voice_d    = voice_q;
      trig_d     = '0;
      steal_d    = 1'b0;
      err_d      = 1'b0;
      target_idx = '0;
      case (state_q)
         StIdle: begin
            if (ev_valid) begin
               on_d    = ev_on;
               off_d   = ev_off;
               ch_d    = ev_ch;
               note_d  = ev_note;
               vel_d   = ev_vel;
               state_d = StAlloc;
            end
         end
         StAlloc: begin
            state_d = StIdle;
            if (on_q == off_q) begin
               err_d = 1'b1;
            end else if (on_q && vel_q != '0) begin
               if (match_found) begin
                  target_idx = match_idx;
               end else if (free_found) begin
                  target_idx = free_idx;
               end else begin
                  target_idx = oldest_idx;
                  steal_d    = 1'b1;
               end
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (IDX_W'(i) == target_idx) begin
                     voice_d[i].gate = 1'b1;
                     voice_d[i].ch   = ch_q;
                     voice_d[i].note = note_q;
                     voice_d[i].vel  = vel_q;
                     voice_d[i].age  = '0;
                     trig_d[i]       = 1'b1;
                  end else if (voice_q[i].gate && voice_q[i].age != AgeSat) begin
                     voice_d[i].age = voice_q[i].age + 1'b1;
                  end
               end
            end else if (match_found) begin
               // Note-off (or zero-velocity note-on): release only, parameters retained.
               voice_d[match_idx].gate = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         on_q    <= 1'b0;
         off_q   <= 1'b0;
         ch_q    <= '0;
         note_q  <= '0;
         vel_q   <= '0;
         voice_q <= '0;
         trig_q  <= '0;
         steal_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         on_q    <= on_d;
         off_q   <= off_d;
         ch_q    <= ch_d;
         note_q  <= note_d;
         vel_q   <= vel_d;
         voice_q <= voice_d;
         trig_q  <= trig_d;
         steal_q <= steal_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      ev_ready = (state_q == StIdle);
      trig     = trig_q;
      steal    = steal_q;
      err      = err_q;
      for (int i = 0; i < NUM_VOICES; i++) begin
         gate[i]       = voice_q[i].gate;
         voice_ch[i]   = voice_q[i].ch;
         voice_note[i] = voice_q[i].note;
         voice_vel[i]  = voice_q[i].vel;
      end
   end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed, table-driven bench for midi_voice_allocator with 4 voices and 8-bit ages.
module tb_midi_voice_allocator;

   logic             clk;
   logic             rst;
   logic             ev_valid;
   logic             ev_ready;
   logic             ev_on;
   logic             ev_off;
   logic [3:0]       ev_ch;
   logic [6:0]       ev_note;
   logic [6:0]       ev_vel;
   logic [3:0]       gate;
   logic [3:0]       trig;
   logic [3:0][3:0]  voice_ch;
   logic [3:0][6:0]  voice_note;
   logic [3:0][6:0]  voice_vel;
   logic             steal;
   logic             err;

   int n_checks = 0;
   int n_pass   = 0;

   midi_voice_allocator #(
      .NUM_VOICES (4),
      .AGE_W      (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_on      (ev_on),
      .ev_off     (ev_off),
      .ev_ch      (ev_ch),
      .ev_note    (ev_note),
      .ev_vel     (ev_vel),
      .gate       (gate),
      .trig       (trig),
      .voice_ch   (voice_ch),
      .voice_note (voice_note),
      .voice_vel  (voice_vel),
      .steal      (steal),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       on;
      logic       off;
      logic [3:0] ch;
      logic [6:0] note;
      logic [6:0] vel;
      logic [3:0] x_gate;
      logic [3:0] x_trig;
      logic       x_steal;
      logic       x_err;
      int         idx;
      logic [6:0] x_note;
      logic [6:0] x_vel;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Entered and left on a falling edge; event accepted on the first rising edge.
   task automatic apply(input vec_t v, input int k);
      chk($sformatf("v%0d_ready", k), 32'(ev_ready), 32'd1);
      ev_valid = 1'b1;
      ev_on    = v.on;
      ev_off   = v.off;
      ev_ch    = v.ch;
      ev_note  = v.note;
      ev_vel   = v.vel;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_busy", k), 32'(ev_ready), 32'd0);
      ev_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_gate", k), 32'(gate), 32'(v.x_gate));
      chk($sformatf("v%0d_trig", k), 32'(trig), 32'(v.x_trig));
      chk($sformatf("v%0d_steal", k), 32'(steal), 32'(v.x_steal));
      chk($sformatf("v%0d_err", k), 32'(err), 32'(v.x_err));
      chk($sformatf("v%0d_note", k), 32'(voice_note[v.idx]), 32'(v.x_note));
      chk($sformatf("v%0d_vel", k), 32'(voice_vel[v.idx]), 32'(v.x_vel));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_clr", k), {29'd0, trig != 4'd0, steal, err}, 32'd0);
   endtask

   initial begin
      // on off ch note vel | gate trig steal err idx note vel
      vecs[0]  = '{1, 0, 0, 60, 100, 4'b0001, 4'b0001, 0, 0, 0, 60, 100};
      vecs[1]  = '{1, 0, 2, 62,  90, 4'b0011, 4'b0010, 0, 0, 1, 62,  90};
      vecs[2]  = '{1, 0, 0, 64,  80, 4'b0111, 4'b0100, 0, 0, 2, 64,  80};
      vecs[3]  = '{1, 0, 0, 65,  70, 4'b1111, 4'b1000, 0, 0, 3, 65,  70};
      vecs[4]  = '{1, 0, 0, 67,  60, 4'b1111, 4'b0001, 1, 0, 0, 67,  60}; // steal v0 (age 3)
      vecs[5]  = '{1, 0, 2, 62,   0, 4'b1101, 4'b0000, 0, 0, 1, 62,  90}; // vel0 = note-off
      vecs[6]  = '{1, 0, 0, 67,  50, 4'b1101, 4'b0001, 0, 0, 0, 67,  50}; // retrigger
      vecs[7]  = '{1, 0, 0, 70,  40, 4'b1111, 4'b0010, 0, 0, 1, 70,  40}; // free v1
      vecs[8]  = '{1, 0, 0, 72,  30, 4'b1111, 4'b0100, 1, 0, 2, 72,  30}; // steal v2 (age 4)
      vecs[9]  = '{0, 1, 5, 99,   0, 4'b1111, 4'b0000, 0, 0, 0, 67,  50}; // off, no match
      vecs[10] = '{1, 1, 0, 70,  10, 4'b1111, 4'b0000, 0, 1, 1, 70,  40}; // both high
      vecs[11] = '{0, 0, 0, 65,   0, 4'b1111, 4'b0000, 0, 1, 3, 65,  70}; // both low
      vecs[12] = '{0, 1, 0, 65,   0, 4'b0111, 4'b0000, 0, 0, 3, 65,  70}; // off v3
      vecs[13] = '{1, 0, 1, 60,  20, 4'b1111, 4'b1000, 0, 0, 3, 60,  20}; // free v3

      rst      = 1'b1;
      ev_valid = 1'b0;
      ev_on    = 1'b0;
      ev_off   = 1'b0;
      ev_ch    = '0;
      ev_note  = '0;
      ev_vel   = '0;
      #1;
      chk("rst_gate", 32'(gate), 32'd0);
      chk("rst_trig", 32'(trig), 32'd0);
      chk("rst_flags", {30'd0, steal, err}, 32'd0);
      chk("rst_note0", 32'(voice_note[0]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 32'(ev_ready), 32'd1);

      for (int k = 0; k < 14; k++) apply(vecs[k], k);

      // Ages now v0=3 v1=2 v2=1 v3=0: v0 is stolen. Valid stays high and the note
      // changes during ALLOC; neither may affect the result.
      ev_valid = 1'b1;
      ev_on    = 1'b1;
      ev_off   = 1'b0;
      ev_ch    = 4'd4;
      ev_note  = 7'd20;
      ev_vel   = 7'd11;
      @(posedge clk);
      @(negedge clk);
      chk("hold_busy", 32'(ev_ready), 32'd0);
      ev_note = 7'd21;
      @(posedge clk);
      @(negedge clk);
      ev_valid = 1'b0;
      chk("hold_trig", 32'(trig), 32'b0001);
      chk("hold_steal", 32'(steal), 32'd1);
      chk("hold_note", 32'(voice_note[0]), 32'd20);
      chk("hold_ch", 32'(voice_ch[0]), 32'd4);
      @(posedge clk);
      @(negedge clk);
      chk("hold_no_second", 32'(trig), 32'd0);
      chk("hold_gate", 32'(gate), 32'b1111);

      // Reset while ALLOC holds a pending event.
      ev_valid = 1'b1;
      ev_ch    = 4'd0;
      ev_note  = 7'd1;
      ev_vel   = 7'd1;
      @(posedge clk);
      @(negedge clk);
      ev_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk("ralloc_gate", 32'(gate), 32'd0);
      chk("ralloc_ready", 32'(ev_ready), 32'd1);
      chk("ralloc_note0", 32'(voice_note[0]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("ralloc_ready_rel", 32'(ev_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("ralloc_trig", 32'(trig), 32'd0);
      chk("ralloc_flags", {28'd0, gate}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
